// File: rtl/s011hd1p_x32y2d128_bw_model_pkg.sv
// ============================================================================
// Module : s011hd1p_x32y2d128_bw_model_pkg
// Brief  : Shared geometry constants and access decode for the 64x128 SRAM.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package s011hd1p_x32y2d128_bw_model_pkg;

    localparam int c_ADDR_WIDTH = 6;
    localparam int c_DATA_WIDTH = 128;
    localparam int c_DEPTH      = 64;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } sram_op_e;

    // Macro pins are active-low: CEN=0 selects, WEN=0 writes.
    function automatic sram_op_e decode_op(input logic cen, input logic wen);
        if (cen)
            return OP_IDLE;
        else if (wen)
            return OP_READ;
        else
            return OP_WRITE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/s011hd1p_x32y2d128_bw_model.sv
// ============================================================================
// Module : s011hd1p_x32y2d128_bw_model
// Brief  : Single-port synchronous SRAM model with per-bit write enable.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module s011hd1p_x32y2d128_bw_model
    import s011hd1p_x32y2d128_bw_model_pkg::*;
#(
    parameter int ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int DEPTH      = c_DEPTH
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  CEN,
    input  logic                  WEN,
    input  logic [DATA_WIDTH-1:0] BWEN,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] q_q;
    logic [DATA_WIDTH-1:0] q_d;

    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [DATA_WIDTH-1:0] w_merged;
    sram_op_e              w_op;

    assign w_op      = decode_op(CEN, WEN);
    assign w_rd_word = mem_q[A];

    generate
        for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bwen_merge
            assign w_merged[i] = BWEN[i] ? w_rd_word[i] : D[i];
        end
    endgenerate

    // Q only moves on a read; writes and idle cycles leave it untouched.
    always_comb begin
        mem_d = mem_q;
        q_d   = q_q;
        case (w_op)
            OP_READ:  q_d      = w_rd_word;
            OP_WRITE: mem_d[A] = w_merged;
            default:  ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mem_q <= '{default: '0};
            q_q   <= '0;
        end else begin
            mem_q <= mem_d;
            q_q   <= q_d;
        end
    end

    assign Q = q_q;

endmodule

`default_nettype wire

// File: tb/tb_s011hd1p_x32y2d128_bw_model.sv
// ============================================================================
// Module : tb_s011hd1p_x32y2d128_bw_model
// Brief  : Randomized and directed self-checking bench for the 64x128 SRAM.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_s011hd1p_x32y2d128_bw_model;

    localparam int AW = 6;
    localparam int DW = 128;
    localparam int NW = 64;

    logic          clk;
    logic          rst_n;
    logic          cen;
    logic          wen;
    logic [DW-1:0] bwen;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] q;

    logic [DW-1:0] model_mem [NW];
    logic [DW-1:0] model_q;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [DW-1:0] FULL_WORD = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [DW-1:0] PART_WORD = 128'h0123456789ABCDFF_FEDCBA9876543210;

    s011hd1p_x32y2d128_bw_model dut (
        .CLK  (clk),
        .RST_N(rst_n),
        .CEN  (cen),
        .WEN  (wen),
        .BWEN (bwen),
        .A    (a),
        .D    (d),
        .Q    (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NW; k++) model_mem[k] = '0;
        model_q = '0;
    endtask

    // Reference behaviour of one clock edge, computed from word-level rules.
    task automatic model_edge(input logic c, input logic w, input logic [DW-1:0] be,
                              input logic [AW-1:0] ad, input logic [DW-1:0] dd);
        if (!c) begin
            if (w) model_q = model_mem[ad];
            else   model_mem[ad] = (model_mem[ad] & be) | (dd & ~be);
        end
    endtask

    // Inputs change at negedge; Q is checked at the following negedge.
    task automatic cycle(input logic c, input logic w, input logic [DW-1:0] be,
                         input logic [AW-1:0] ad, input logic [DW-1:0] dd);
        cen = c; wen = w; bwen = be; a = ad; d = dd;
        @(posedge clk);
        model_edge(c, w, be, ad, dd);
        @(negedge clk);
        chk("cycle_q", q, model_q);
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [DW-1:0] new6;
    logic [DW-1:0] ones;

    initial begin
        ones  = '1;
        rst_n = 1'b0;
        cen = 1'b1; wen = 1'b1; bwen = '1; a = '0; d = '0;
        model_clear();
        repeat (3) @(negedge clk);
        chk("reset_q_low", q, '0);
        rst_n = 1'b1;

        cycle(1'b0, 1'b1, ones, 6'h00, '0);
        chk("reset_rd_00", q, '0);
        cycle(1'b0, 1'b1, ones, 6'h3F, '0);
        chk("reset_rd_3f", q, '0);

        cycle(1'b0, 1'b0, '0, 6'h05, FULL_WORD);
        cycle(1'b0, 1'b1, ones, 6'h05, '0);
        chk("full_write", q, FULL_WORD);

        cycle(1'b0, 1'b0, ~(128'hFF << 64), 6'h05, ones);
        cycle(1'b0, 1'b1, ones, 6'h05, '0);
        chk("partial_write", q, PART_WORD);

        cycle(1'b0, 1'b1, ones, 6'h3F, '0);
        chk("q_before_hold", q, '0);
        cycle(1'b1, 1'b0, '0, 6'h05, '0);
        chk("cen_hold_q", q, '0);
        cycle(1'b0, 1'b1, ones, 6'h05, '0);
        chk("cen_hold_mem", q, PART_WORD);

        new6 = rnd128();
        cycle(1'b0, 1'b1, ones, 6'h05, '0);
        cycle(1'b0, 1'b0, '0, 6'h06, new6);
        chk("write_q_hold", q, PART_WORD);
        cycle(1'b0, 1'b1, ones, 6'h06, '0);
        chk("read_new6", q, new6);

        cycle(1'b0, 1'b1, ones, 6'h05, '0);
        chk("b2b_rd5", q, PART_WORD);
        cycle(1'b0, 1'b1, ones, 6'h06, '0);
        chk("b2b_rd6", q, new6);

        cycle(1'b0, 1'b0, ones, 6'h05, '0);
        chk("bwen_ones_qhold", q, new6);
        cycle(1'b0, 1'b1, ones, 6'h05, '0);
        chk("bwen_ones_nowrite", q, PART_WORD);

        for (int n = 0; n < 600; n++) begin
            logic          rc;
            logic          rw;
            logic [DW-1:0] rb;
            rc = ($urandom_range(0, 7) == 0);
            rw = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 2))
                0:       rb = '0;
                1:       rb = ones;
                default: rb = rnd128();
            endcase
            cycle(rc, rw, rb, AW'($urandom_range(0, 7)), rnd128());
        end

        // Reset asserted asynchronously while a write is pending.
        cen = 1'b0; wen = 1'b0; bwen = '0; a = 6'h02; d = ones;
        #2 rst_n = 1'b0;
        #1 chk("async_reset_q", q, '0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b1, ones, AW'(k), '0);
            chk("post_reset_zero", q, '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/s011hd1p_x32y2d128_bw_model.md
S011HD1P_X32Y2D128_BW_MODEL -- requirements
Module: s011hd1p_x32y2d128_bw

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 128, word and bit-mask width.
REQ-003 SHALL have parameter DEPTH, default 64 (2**ADDR_WIDTH), number of words.
REQ-004 SHALL have port CLK  input  1  single clock; all array and Q updates on the rising edge.
REQ-005 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port CEN  input  1  chip enable, active-low.
REQ-007 SHALL have port WEN  input  1  write enable, active-low; 1 means read.
REQ-008 SHALL have port BWEN  input  DATA_WIDTH  per-bit write enable, active-low; 0 means write that bit.
REQ-009 SHALL have port A  input  ADDR_WIDTH  word address.
REQ-010 SHALL have port D  input  DATA_WIDTH  write data.
REQ-011 SHALL have port Q  output  DATA_WIDTH  registered read data.

Function
REQ-012 SHALL be a single-port synchronous SRAM of DEPTH x DATA_WIDTH bits with one access per cycle.
REQ-013 SHALL perform a read when CEN=0 and WEN=1 at a rising CLK edge: Q <= mem[A].
REQ-014 SHALL return read data on Q from the edge that samples the read, i.e. 1-cycle latency, with Q valid until the next read edge.
REQ-015 SHALL perform a write when CEN=0 and WEN=0 at a rising CLK edge: for each bit i, mem[A][i] <= D[i] if BWEN[i]=0, else it keeps its old value.
REQ-016 SHALL leave Q unchanged during a write cycle, with no write-through.
REQ-017 SHALL make the write visible to a read of the same address issued in the next cycle.
REQ-018 SHALL, when CEN=1, hold both the array and Q regardless of WEN, BWEN, A and D.
REQ-019 SHALL write nothing on a write with BWEN all-ones, while Q is still held.
REQ-020 SHALL use an A value that is always in range, since DEPTH = 2**ADDR_WIDTH; no out-of-range handling is needed.
REQ-021 SHALL NOT depend on input timing between edges, as the array has no combinational read path.

Reset
REQ-022 SHALL, while RST_N=0 (asynchronous), force Q to all zeros and clear every array word to zero.
REQ-023 SHALL ignore CLK-edge accesses while RST_N=0.
REQ-024 SHALL service the first access at the first rising CLK edge after RST_N deasserts.
REQ-025 SHALL, on reset mid-operation, abort any pending write, which then does not take effect.

Structure
REQ-026 SHALL keep ADDR_WIDTH, DATA_WIDTH and DEPTH defaults as constants in the shared memory package, so that cache wrappers instantiate matching macros.
REQ-027 SHALL be a single flat module with no sub-modules: one memory array plus one Q register, with a generate loop over bits for the BWEN merge.

Verification
REQ-028 SHALL be covered by a reset check: after RST_N low then high, a read of A=0x00 and of A=0x3F returns Q=0.
REQ-029 SHALL be covered by a full write: A=0x05, D=0x0123456789ABCDEF_FEDCBA9876543210, BWEN=0, then a read of A=0x05 returns Q=0x0123456789ABCDEF_FEDCBA9876543210 one cycle after the read edge.
REQ-030 SHALL be covered by a partial write: on that word, write D=all-ones with BWEN=~(0xFF<<64), then a read returns 0x0123456789ABCDFF_FEDCBA9876543210.
REQ-031 SHALL be covered by a CEN hold: with CEN=1, WEN=0, A=0x05, D=0, BWEN=0, the word is unchanged on the next read and Q keeps its prior value throughout.
REQ-032 SHALL be covered by a write-Q-hold check: read A=0x05, then write A=0x06; during the write Q still shows the A=0x05 data, and a subsequent read of A=0x06 returns the new data.
REQ-033 SHALL be covered by back-to-back reads of A=0x05 then 0x06 on consecutive cycles, with Q updating each cycle accordingly.
